// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle MIPS datapath. It runs one instruction at a time.
// Datapath controls are decoded from the next state and registered, so they are valid at the start of each cycle.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic       Stall,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic [1:0] PCSource,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       IllegalOp,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_RST       = 4'd0,  S_FETCH    = 4'd1,  S_DECODE   = 4'd2,  S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,  S_MEM_WB   = 4'd5,  S_MEM_WRITE = 4'd6, S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,  S_BEQ      = 4'd9,  S_BNE      = 4'd10, S_JUMP      = 4'd11,
    S_JAL       = 4'd12, S_ADDI_EXEC = 4'd13, S_ADDI_WB = 4'd14, S_ILLEGAL   = 4'd15
  } state_t;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic [1:0] pcsource;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       illegal;
  } ctrl_t;

  state_t st;
  ctrl_t  ctl;
  logic   is_sw;
  logic   stall_hold;

  function automatic state_t next_state(state_t s, logic [5:0] op, logic stall, logic sw);
    next_state = S_FETCH;
    case (s)
      S_RST:       next_state = S_FETCH;
      S_FETCH:     next_state = stall ? S_FETCH : S_DECODE;
      S_DECODE: begin
        case (op)
          6'b000000:            next_state = S_R_EXEC;
          6'b100011, 6'b101011: next_state = S_MEM_ADDR;
          6'b000100:            next_state = S_BEQ;
          6'b000101:            next_state = S_BNE;
          6'b000010:            next_state = S_JUMP;
          6'b000011:            next_state = S_JAL;
          6'b001000:            next_state = S_ADDI_EXEC;
          default:              next_state = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR:  next_state = sw ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  next_state = stall ? S_MEM_READ : S_MEM_WB;
      S_MEM_WRITE: next_state = stall ? S_MEM_WRITE : S_FETCH;
      S_R_EXEC:    next_state = S_R_WB;
      S_ADDI_EXEC: next_state = S_ADDI_WB;
      default:     next_state = S_FETCH;
    endcase
  endfunction

  function automatic ctrl_t decode(state_t s);
    decode = '0;
    case (s)
      S_FETCH: begin
        decode.memread = 1'b1; decode.irwrite = 1'b1; decode.pcwrite = 1'b1;
        decode.alusrcb = 2'b01;
      end
      S_DECODE:    decode.alusrcb = 2'b11;
      S_MEM_ADDR:  begin decode.alusrca = 1'b1; decode.alusrcb = 2'b10; end
      S_MEM_READ:  begin decode.memread = 1'b1; decode.iord = 1'b1; end
      S_MEM_WB:    begin decode.regwrite = 1'b1; decode.memtoreg = 2'b01; end
      S_MEM_WRITE: begin decode.memwrite = 1'b1; decode.iord = 1'b1; end
      S_R_EXEC:    begin decode.alusrca = 1'b1; decode.aluop = 2'b10; end
      S_R_WB:      begin decode.regwrite = 1'b1; decode.regdst = 2'b01; end
      S_BEQ, S_BNE: begin
        decode.pcwritecond = 1'b1; decode.alusrca = 1'b1; decode.aluop = 2'b01;
        decode.pcsource = (s == S_BEQ) ? 2'b01 : 2'b10;
      end
      S_JUMP:      begin decode.pcwrite = 1'b1; decode.pcsource = 2'b11; end
      S_JAL: begin
        decode.pcwrite = 1'b1; decode.pcsource = 2'b11; decode.regwrite = 1'b1;
        decode.regdst = 2'b10; decode.memtoreg = 2'b10;
      end
      S_ADDI_EXEC: begin decode.alusrca = 1'b1; decode.alusrcb = 2'b10; end
      S_ADDI_WB:   decode.regwrite = 1'b1;
      S_ILLEGAL:   decode.illegal = 1'b1;
      default:     decode = '0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      st    <= S_RST;
      ctl   <= '0;
      is_sw <= 1'b0;
    end else begin
      st  <= next_state(st, Opcode, Stall, is_sw);
      ctl <= decode(next_state(st, Opcode, Stall, is_sw));
      if (st == S_DECODE) is_sw <= Opcode[3];
    end
  end

  // Stall is the one input that reaches the outputs. It can only clear write strobes during a memory wait.
  assign stall_hold = Stall && (st == S_FETCH || st == S_MEM_READ || st == S_MEM_WRITE);

  assign PCWrite     = ctl.pcwrite     & ~stall_hold;
  assign PCWriteCond = ctl.pcwritecond & ~stall_hold;
  assign IRWrite     = ctl.irwrite     & ~stall_hold;
  assign MemWrite    = ctl.memwrite    & ~stall_hold;
  assign RegWrite    = ctl.regwrite    & ~stall_hold;
  assign PCSource    = ctl.pcsource;
  assign IorD        = ctl.iord;
  assign MemRead     = ctl.memread;
  assign RegDst      = ctl.regdst;
  assign MemtoReg    = ctl.memtoreg;
  assign ALUSrcA     = ctl.alusrca;
  assign ALUSrcB     = ctl.alusrcb;
  assign ALUOp       = ctl.aluop;
  assign IllegalOp   = ctl.illegal;
  assign State       = st;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl. Each instruction vector lists its expected state trace and its stall pattern.
// Expected outputs per state come from the state table and go through a scoreboard queue.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic [1:0] pcsource;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       illegal;
  } ctl_t;

  typedef struct {
    logic [3:0] st;
    ctl_t       o;
  } exp_t;

  typedef struct {
    string           name;
    logic [5:0]      op;
    int              n;
    logic [7:0][3:0] seq;   // nibble i = expected state in cycle i (read right-to-left)
    logic [7:0]      stl;   // bit i = Stall driven in cycle i
  } vec_t;

  logic       clk, reset, Stall;
  logic [5:0] Opcode;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA, IllegalOp;
  logic [1:0] PCSource, RegDst, MemtoReg, ALUSrcB, ALUOp;
  logic [3:0] State;
  ctl_t       got;

  int errors = 0;
  int checks = 0;
  exp_t sb[$];
  vec_t vecs[13];

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Stall(Stall),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .IllegalOp(IllegalOp), .State(State)
  );

  assign got = {PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
                RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, IllegalOp};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ctl_t exp_out(logic [3:0] s, bit stl);
    ctl_t c = '0;
    case (s)
      4'd1:  begin c.memread = 1; c.irwrite = 1; c.pcwrite = 1; c.alusrcb = 2'b01; end
      4'd2:  c.alusrcb = 2'b11;
      4'd3:  begin c.alusrca = 1; c.alusrcb = 2'b10; end
      4'd4:  begin c.memread = 1; c.iord = 1; end
      4'd5:  begin c.regwrite = 1; c.memtoreg = 2'b01; end
      4'd6:  begin c.memwrite = 1; c.iord = 1; end
      4'd7:  begin c.alusrca = 1; c.aluop = 2'b10; end
      4'd8:  begin c.regwrite = 1; c.regdst = 2'b01; end
      4'd9:  begin c.pcwritecond = 1; c.pcsource = 2'b01; c.alusrca = 1; c.aluop = 2'b01; end
      4'd10: begin c.pcwritecond = 1; c.pcsource = 2'b10; c.alusrca = 1; c.aluop = 2'b01; end
      4'd11: begin c.pcwrite = 1; c.pcsource = 2'b11; end
      4'd12: begin c.pcwrite = 1; c.pcsource = 2'b11; c.regwrite = 1; c.regdst = 2'b10; c.memtoreg = 2'b10; end
      4'd13: begin c.alusrca = 1; c.alusrcb = 2'b10; end
      4'd14: c.regwrite = 1;
      4'd15: c.illegal = 1;
      default: c = '0;
    endcase
    if (stl && (s == 4'd1 || s == 4'd4 || s == 4'd6)) begin
      c.pcwrite = 0; c.pcwritecond = 0; c.irwrite = 0; c.memwrite = 0; c.regwrite = 0;
    end
    return c;
  endfunction

  // One cycle: drive inputs at negedge, push the expectation, then compare after the inputs have settled.
  task automatic cyc(input logic [3:0] es, input bit stl, input logic [5:0] op, input bit rst,
                     input string nm);
    exp_t e;
    @(negedge clk);
    reset = rst; Stall = stl; Opcode = op;
    sb.push_back('{st: es, o: exp_out(es, stl)});
    #1;
    e = sb.pop_front();
    checks++;
    if (State !== e.st) begin
      errors++;
      $display("FAIL %s state: got %0d want %0d", nm, State, e.st);
    end
    checks++;
    if (got !== e.o) begin
      errors++;
      $display("FAIL %s outputs (state %0d): got %h want %h", nm, e.st, got, e.o);
    end
  endtask

  initial begin
    vecs[0]  = '{"lw",        6'b100011, 5, 32'h00054321, 8'b0000000};
    vecs[1]  = '{"sw",        6'b101011, 4, 32'h00006321, 8'b0000000};
    vecs[2]  = '{"rtype",     6'b000000, 4, 32'h00008721, 8'b0000000};
    vecs[3]  = '{"addi",      6'b001000, 4, 32'h0000ED21, 8'b0000000};
    vecs[4]  = '{"beq",       6'b000100, 3, 32'h00000921, 8'b0000000};
    vecs[5]  = '{"bne",       6'b000101, 3, 32'h00000A21, 8'b0000000};
    vecs[6]  = '{"j",         6'b000010, 3, 32'h00000B21, 8'b0000000};
    vecs[7]  = '{"jal",       6'b000011, 3, 32'h00000C21, 8'b0000000};
    vecs[8]  = '{"illegal",   6'b111111, 3, 32'h00000F21, 8'b0000010};
    vecs[9]  = '{"sw_stall3", 6'b101011, 7, 32'h06666321, 8'b0111000};
    vecs[10] = '{"lw_fstall", 6'b100011, 7, 32'h05432111, 8'b0000011};
    vecs[11] = '{"lw_rstall", 6'b100011, 6, 32'h00544321, 8'b0001000};
    vecs[12] = '{"r_wbstall", 6'b000000, 4, 32'h00008721, 8'b0001000};

    reset = 1'b1; Stall = 1'b0; Opcode = 6'b0;
    cyc(4'd0, 1'b1, 6'b0, 1'b1, "reset_hold");
    cyc(4'd0, 1'b0, 6'b0, 1'b0, "reset_last");

    // Opcode is driven as its complement outside DECODE, so a design that uses the live input fails.
    for (int v = 0; v < 13; v++) begin
      for (int i = 0; i < vecs[v].n; i++) begin
        cyc(vecs[v].seq[i], vecs[v].stl[i],
            (vecs[v].seq[i] == 4'd2) ? vecs[v].op : ~vecs[v].op, 1'b0, vecs[v].name);
      end
    end

    // Reset arrives during R_EXEC and is held for two edges, with Stall high to confirm reset wins.
    cyc(4'd1, 1'b0, 6'b111111, 1'b0, "rst_mid_fetch");
    cyc(4'd2, 1'b0, 6'b000000, 1'b0, "rst_mid_decode");
    cyc(4'd7, 1'b0, 6'b111111, 1'b1, "rst_mid_rexec");
    cyc(4'd0, 1'b1, 6'b111111, 1'b1, "rst_mid_rst1");
    cyc(4'd0, 1'b0, 6'b111111, 1'b0, "rst_mid_rst2");
    cyc(4'd1, 1'b0, 6'b111111, 1'b0, "rst_release_fetch");
    cyc(4'd2, 1'b0, 6'b001000, 1'b0, "post_rst_decode");
    cyc(4'd13, 1'b0, 6'b110111, 1'b0, "post_rst_addi");
    cyc(4'd14, 1'b0, 6'b110111, 1'b0, "post_rst_addi_wb");
    cyc(4'd1, 1'b0, 6'b110111, 1'b0, "post_rst_refetch");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
